// File: rtl/ikaopll_slotgen.sv
// Slot/timing generator: phi1 clock enables from phiM, subcycle/group slot
// counter, frame counter, group delay line and per-slot decode outputs.
module ikaopll_slotgen #(
    parameter int                PHI_DIV  = 4,
    parameter int                SUBCYC   = 6,
    parameter int                GROUPS   = 3,
    parameter int                NMATCH   = 4,
    parameter int                DLY      = 2,
    parameter logic [SUBCYC-1:0] MNC_MASK = 6'b100011,
    parameter int                FRAMEW   = 8,
    localparam int               SLOTS    = SUBCYC * GROUPS,
    localparam int               SLOTW    = $clog2(SLOTS),
    localparam int               SCW      = $clog2(SUBCYC),
    localparam int               GW       = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                    i_EMUCLK,
    input  logic                    i_IC_n,
    input  logic                    i_phiM_PCEN_n,
    input  logic                    i_HOLD,
    input  logic                    i_RHYTHM_EN,
    input  logic [NMATCH*SLOTW-1:0] i_MATCH_VAL,
    output logic                    o_phi1_PCEN_n,
    output logic                    o_phi1_NCEN_n,
    output logic [SLOTW-1:0]        o_SLOT,
    output logic [SCW-1:0]          o_SUBCYC,
    output logic [GW-1:0]           o_GROUP,
    output logic [GW-1:0]           o_GROUP_DLY,
    output logic [NMATCH-1:0]       o_MATCH,
    output logic                    o_FRAME_TICK,
    output logic [FRAMEW-1:0]       o_FRAME_CNT,
    output logic                    o_RHYTHM_ACT,
    output logic                    o_MnC_SEL
);

    localparam int             DW       = (PHI_DIV > 1) ? $clog2(PHI_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(PHI_DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF = DW'(PHI_DIV / 2);
    localparam logic [SCW-1:0] SUB_LAST = SCW'(SUBCYC - 1);
    localparam logic [GW-1:0]  GRP_LAST = GW'(GROUPS - 1);

    logic            pcen;
    logic            ic_sync_p0, ic_sync_p1, ic_sync_p2;
    logic            init;
    logic            run;
    logic [DW-1:0]   div;
    logic            phi_p, phi_n;
    logic            adv;
    logic            frame_wrap;
    logic [SCW-1:0]  sub;
    logic [GW-1:0]   grp;
    logic [FRAMEW-1:0] frame;
    logic            rhythm;
    logic [GW-1:0]   dly [DLY];

    assign pcen = ~i_phiM_PCEN_n;

    // Reset release synchroniser; the async clear holds it at zero while i_IC_n is low
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            ic_sync_p0 <= 1'b0;
            ic_sync_p1 <= 1'b0;
            ic_sync_p2 <= 1'b0;
        end else if (pcen) begin
            ic_sync_p0 <= 1'b1;
            ic_sync_p1 <= ic_sync_p0;
            ic_sync_p2 <= ic_sync_p1;
        end
    end

    // init is the one-enable window between the p1 and p2 rising; run opens after it
    assign init = ic_sync_p1 & ~ic_sync_p2;
    assign run  = ic_sync_p2;

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            div <= '0;
        end else if (pcen) begin
            if (init || div == DIV_LAST) begin
                div <= '0;
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    assign phi_p         = pcen & run & (div == '0);
    assign phi_n         = pcen & run & (div == DIV_HALF);
    assign o_phi1_PCEN_n = ~phi_p;
    assign o_phi1_NCEN_n = ~phi_n;

    assign adv        = phi_n & ~i_HOLD;
    assign frame_wrap = adv & (sub == SUB_LAST) & (grp == GRP_LAST);

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            sub    <= '0;
            grp    <= '0;
            frame  <= '0;
            rhythm <= 1'b0;
            for (int k = 0; k < DLY; k++) begin
                dly[k] <= '0;
            end
        end else if (pcen && init) begin
            sub    <= '0;
            grp    <= '0;
            frame  <= '0;
            rhythm <= i_RHYTHM_EN;
            for (int k = 0; k < DLY; k++) begin
                dly[k] <= '0;
            end
        end else if (adv) begin
            dly[0] <= grp;
            for (int k = 1; k < DLY; k++) begin
                dly[k] <= dly[k-1];
            end
            if (sub == SUB_LAST) begin
                sub <= '0;
                if (grp == GRP_LAST) begin
                    grp <= '0;
                    frame <= frame + FRAMEW'(1);
                end else begin
                    grp <= grp + GW'(1);
                end
            end else begin
                sub <= sub + SCW'(1);
            end
            if (frame_wrap) begin
                rhythm <= i_RHYTHM_EN;
            end
        end
    end

    assign o_SUBCYC     = sub;
    assign o_GROUP      = grp;
    assign o_GROUP_DLY  = dly[DLY-1];
    assign o_FRAME_CNT  = frame;
    assign o_RHYTHM_ACT = rhythm;
    assign o_SLOT       = SLOTW'(grp) * SLOTW'(SUBCYC) + SLOTW'(sub);
    assign o_FRAME_TICK = (o_SLOT == SLOTW'(SLOTS - 1));
    assign o_MnC_SEL    = MNC_MASK[sub];

    // o_SLOT never reaches SLOTS, so an out-of-range compare value cannot match
    always_comb begin
        o_MATCH = '0;
        for (int n = 0; n < NMATCH; n++) begin
            if (i_MATCH_VAL[n*SLOTW +: SLOTW] == o_SLOT) begin
                o_MATCH[n] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ikaopll_slotgen.sv
// Randomised bench for ikaopll_slotgen: default and reduced configurations
// compared cycle by cycle against a slot-count reference model.
module tb_ikaopll_slotgen;

    localparam int PD   [2] = '{4, 2};
    localparam int SC   [2] = '{6, 4};
    localparam int GR   [2] = '{3, 2};
    localparam int DL   [2] = '{3 - 1, 3};
    localparam int MASK [2] = '{35, 3};
    localparam int MW   [2] = '{5, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ic_n, phim_n, hold, rhythm;
    logic [19:0] mv_a;
    logic [11:0] mv_b;

    logic       p_a, n_a, tick_a, rhy_a, mnc_a;
    logic [4:0] slot_a;
    logic [2:0] sub_a;
    logic [1:0] grp_a, gdly_a;
    logic [3:0] match_a;
    logic [7:0] frame_a;

    logic       p_b, n_b, tick_b, rhy_b, mnc_b;
    logic [2:0] slot_b;
    logic [1:0] sub_b;
    logic [0:0] grp_b, gdly_b;
    logic [3:0] match_b;
    logic [7:0] frame_b;

    ikaopll_slotgen u_a (
        .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(phim_n), .i_HOLD(hold),
        .i_RHYTHM_EN(rhythm), .i_MATCH_VAL(mv_a),
        .o_phi1_PCEN_n(p_a), .o_phi1_NCEN_n(n_a), .o_SLOT(slot_a), .o_SUBCYC(sub_a),
        .o_GROUP(grp_a), .o_GROUP_DLY(gdly_a), .o_MATCH(match_a), .o_FRAME_TICK(tick_a),
        .o_FRAME_CNT(frame_a), .o_RHYTHM_ACT(rhy_a), .o_MnC_SEL(mnc_a)
    );

    ikaopll_slotgen #(
        .PHI_DIV(2), .SUBCYC(4), .GROUPS(2), .DLY(3), .MNC_MASK(4'b0011)
    ) u_b (
        .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(phim_n), .i_HOLD(hold),
        .i_RHYTHM_EN(rhythm), .i_MATCH_VAL(mv_b),
        .o_phi1_PCEN_n(p_b), .o_phi1_NCEN_n(n_b), .o_SLOT(slot_b), .o_SUBCYC(sub_b),
        .o_GROUP(grp_b), .o_GROUP_DLY(gdly_b), .o_MATCH(match_b), .o_FRAME_TICK(tick_b),
        .o_FRAME_CNT(frame_b), .o_RHYTHM_ACT(rhy_b), .o_MnC_SEL(mnc_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: phiM enables since release (e) and unheld slot steps since init (n)
    int     e;
    longint n   [2];
    bit     rhy [2];

    task automatic model_clear();
        e = 0;
        for (int i = 0; i < 2; i++) begin
            n[i]   = 0;
            rhy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!ic_n) begin
            model_clear();
        end else if (!phim_n) begin
            e++;
            for (int i = 0; i < 2; i++) begin
                if (e == 3) begin
                    n[i]   = 0;
                    rhy[i] = rhythm;
                end else if (e >= 4 && ((e - 4) % PD[i]) == PD[i] / 2 && !hold) begin
                    n[i]++;
                    if (n[i] % (SC[i] * GR[i]) == 0) rhy[i] = rhythm;
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input int os, input int osub, input int ogrp,
                              input int ogdly, input int omatch, input int otick,
                              input int oframe, input int orhy, input int omnc,
                              input int op, input int on, input longint mv);
        string  nm;
        int     slots, s, esub, egdly, ematch, val;
        bit     act;
        slots = SC[i] * GR[i];
        nm    = (i == 0) ? "A" : "B";
        s     = int'(n[i] % slots);
        esub  = s % SC[i];
        egdly = (n[i] >= DL[i]) ? int'(((n[i] - DL[i]) % slots) / SC[i]) : 0;
        ematch = 0;
        for (int c = 0; c < 4; c++) begin
            val = int'((mv >> (c * MW[i])) & ((1 << MW[i]) - 1));
            if (val == s) ematch |= (1 << c);
        end
        act = !phim_n && e >= 3;
        chk({nm, ".slot"},  os,     s);
        chk({nm, ".sub"},   osub,   esub);
        chk({nm, ".grp"},   ogrp,   s / SC[i]);
        chk({nm, ".gdly"},  ogdly,  egdly);
        chk({nm, ".match"}, omatch, ematch);
        chk({nm, ".tick"},  otick,  (s == slots - 1) ? 1 : 0);
        chk({nm, ".frame"}, oframe, int'((n[i] / slots) % 256));
        chk({nm, ".rhy"},   orhy,   rhy[i]);
        chk({nm, ".mnc"},   omnc,   (MASK[i] >> esub) & 1);
        chk({nm, ".pcen"},  op,     (act && (e - 3) % PD[i] == 0) ? 0 : 1);
        chk({nm, ".ncen"},  on,     (act && (e - 3) % PD[i] == PD[i] / 2) ? 0 : 1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_inst(0, slot_a, sub_a, grp_a, gdly_a, match_a, tick_a, frame_a, rhy_a,
                   mnc_a, p_a, n_a, longint'(mv_a));
        check_inst(1, slot_b, sub_b, grp_b, gdly_b, match_b, tick_b, frame_b, rhy_b,
                   mnc_b, p_b, n_b, longint'(mv_b));
    endtask

    task automatic wait_slot(input int target, input int budget);
        int k = 0;
        while (int'(slot_a) != target && k < budget) begin
            step();
            k++;
        end
        chk("wait_slot", slot_a, target);
    endtask

    int frame_save;

    initial begin
        ic_n   = 1'b0;
        phim_n = 1'b0;
        hold   = 1'b0;
        rhythm = 1'b0;
        mv_a   = {5'd20, 5'd0, 5'd17, 5'd5};
        mv_b   = {3'd7, 3'd0, 3'd5, 3'd2};
        model_clear();
        repeat (3) step();
        chk("rst.slot",  slot_a, 0);
        chk("rst.frame", frame_a, 0);
        chk("rst.pcen",  p_a, 1);
        chk("rst.ncen",  n_a, 1);
        chk("rst.rhy",   rhy_a, 0);
        chk("rst.gdly",  gdly_b, 0);

        ic_n = 1'b1;
        wait_slot(7, 200);
        rhythm = 1'b1;
        step();
        chk("rhy.mid", rhy_a, 0);
        wait_slot(17, 100);
        chk("rhy.pre", rhy_a, 0);
        wait_slot(0, 10);
        chk("rhy.wrap", rhy_a, 1);

        wait_slot(9, 100);
        hold       = 1'b1;
        frame_save = frame_a;
        repeat (40) step();
        chk("hold.slot",  slot_a, 9);
        chk("hold.frame", frame_a, frame_save);
        hold = 1'b0;
        wait_slot(10, 6);

        wait_slot(12, 100);
        ic_n = 1'b0;
        model_clear();
        #1;
        chk("arst.slot",  slot_a, 0);
        chk("arst.frame", frame_a, 0);
        repeat (3) step();
        ic_n = 1'b1;
        wait_slot(1, 40);
        chk("arst.restart", frame_a, 0);
        wait_slot(0, 100);
        chk("arst.wrap", frame_a, 1);

        for (int it = 0; it < 4000; it++) begin
            phim_n = ($urandom_range(0, 3) == 0);
            hold   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) rhythm = ~rhythm;
            if ($urandom_range(0, 99) == 0) begin
                mv_a = 20'($urandom);
                mv_b = 12'($urandom);
            end
            if ($urandom_range(0, 799) == 0) begin
                ic_n = 1'b0;
                model_clear();
                repeat ($urandom_range(1, 3)) step();
                ic_n = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ikaopll_slotgen.md
IKAOPLL_SLOTGEN -- requirements
Module: IKAOPLL_slotgen

Interface
REQ-001 Parameter PHI_DIV, default 4: phiM enables per phi1 period; even, at least 2.
REQ-002 Parameter SUBCYC, default 6: subcycles per group, at least 2.
REQ-003 Parameter GROUPS, default 3: groups per frame, at least 1.
REQ-004 Parameter NMATCH, default 4: number of programmable slot-compare channels, at least 1.
REQ-005 Parameter DLY, default 2: depth of the group-index delay line, at least 1.
REQ-006 Parameter MNC_MASK, default 6'b100011, width SUBCYC: bit k gives o_MnC_SEL for subcycle k.
REQ-007 Parameter FRAMEW, default 8: frame counter width.
REQ-008 Derived SLOTS = SUBCYC*GROUPS; SLOTW = clog2(SLOTS); GW = clog2(GROUPS), minimum 1.
REQ-009 i_EMUCLK  in  1  emulator master clock; one clock, all flops on its rising edge.
REQ-010 i_IC_n  in  1  reset, asynchronous, active-low.
REQ-011 i_phiM_PCEN_n  in  1  phiM clock enable, active low.
REQ-012 i_HOLD  in  1  freezes slot, frame and delay state while high.
REQ-013 i_RHYTHM_EN  in  1  rhythm mode request.
REQ-014 i_MATCH_VAL  in  NMATCH*SLOTW  compare values; channel n at bits [n*SLOTW +: SLOTW].
REQ-015 o_phi1_PCEN_n, o_phi1_NCEN_n  out  1 each  phi1 positive/negative clock enables, active low.
REQ-016 o_SLOT  out  SLOTW  linear slot index, group*SUBCYC + subcycle.
REQ-017 o_SUBCYC  out  clog2(SUBCYC)  subcycle index; o_GROUP  out  GW  group index.
REQ-018 o_GROUP_DLY  out  GW  o_GROUP delayed DLY phi1 cycles.
REQ-019 o_MATCH  out  NMATCH  per-channel slot-compare flags.
REQ-020 o_FRAME_TICK  out  1  high during slot SLOTS-1.
REQ-021 o_FRAME_CNT  out  FRAMEW  completed-frame count.
REQ-022 o_RHYTHM_ACT  out  1  rhythm mode in effect for the current frame.
REQ-023 o_MnC_SEL  out  1  modulator/carrier select.

Function
REQ-024 i_IC_n is synchronised by 2 flops clocked on phiM enables; a rising edge of the synchronised level produces soft-init (init) for exactly one phiM enable.
REQ-025 The phi1 divider counts phiM enables 0..PHI_DIV-1 and wraps to 0.
REQ-026 Phi1 enables: o_phi1_PCEN_n is low only when the divider equals 0 and i_phiM_PCEN_n is low; o_phi1_NCEN_n is low only when the divider equals PHI_DIV/2 and i_phiM_PCEN_n is low.
REQ-027 On init, the divider loads 0 and no phi1 enable is emitted on that phiM enable.
REQ-028 Slot counter: the subcycle advances on each NCEN enable unless i_HOLD is high; wrap from SUBCYC-1 to 0 increments the group; wrap from GROUPS-1 to 0 increments o_FRAME_CNT modulo 2^FRAMEW.
REQ-029 Init clears subcycle, group, frame count and delay line; init overrides i_HOLD.
REQ-030 o_GROUP_DLY is a DLY-stage shift of o_GROUP, shifted on unheld NCEN enables.
REQ-031 o_MATCH[n] is combinational: high when o_SLOT equals channel n of i_MATCH_VAL; a value at or above SLOTS never matches.
REQ-032 o_MnC_SEL = MNC_MASK[o_SUBCYC], combinational.
REQ-033 i_RHYTHM_EN is sampled into o_RHYTHM_ACT only on the NCEN enable that wraps the frame (slot SLOTS-1 to 0) and on init; mid-frame changes have no effect until the next frame.
REQ-034 o_FRAME_TICK = (o_SLOT == SLOTS-1), combinational; it is high for exactly one phi1 cycle per unheld frame.
REQ-035 While i_HOLD is high, the phi1 enables continue and all outputs other than the phi1 enables keep their values.

Reset
REQ-036 When i_IC_n is low, asynchronously: divider 0, all counters 0, delay line 0, o_RHYTHM_ACT 0, synchroniser 0, both phi1 enables high.
REQ-037 While i_IC_n is low, no NCEN/PCEN is emitted.
REQ-038 Init fires once after release; if reset reasserts mid-frame, the async clear takes priority immediately.

Verification
REQ-039 Defaults, i_phiM_PCEN_n held low, release reset: after init, PCEN is low every 4th clock and NCEN 2 clocks later; o_SLOT steps 0..17 and wraps; o_FRAME_TICK is high only at slot 17.
REQ-040 i_MATCH_VAL channels {5, 17, 0, 20}: o_MATCH = 4'b0001 at slot 5, 4'b0010 at slot 17, 4'b0100 at slot 0; channel 3 never fires.
REQ-041 Toggle i_RHYTHM_EN to 1 at slot 7: o_RHYTHM_ACT stays 0 until the wrap 17 to 0, then reads 1.
REQ-042 Assert i_HOLD for 10 NCEN enables at slot 9: o_SLOT stays 9 and o_FRAME_CNT is unchanged; the sequence resumes at 10 on release.
REQ-043 Assert reset at slot 12 for 3 clocks, then release: outputs go to 0 asynchronously; after the synchroniser delay plus init, the sequence restarts at slot 0 with o_FRAME_CNT = 0.
REQ-044 PHI_DIV=2, SUBCYC=4, GROUPS=2, DLY=3: NCEN occurs every 2nd phiM enable; o_SLOT wraps at 7; o_GROUP_DLY lags o_GROUP by 3 NCEN enables; o_MnC_SEL follows the low 4 bits of MNC_MASK.
